// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Time-multiplexed scan stage feeding a BCD-to-seven-segment decoder.
//   A shadow register holds N_DIGITS packed 4-bit codes; one digit at a time
//   is selected for REFRESH_DIV clocks, its code driven on nibble and its
//   active-low anode pulled low. Blanked digits output code 4'hF with all
//   anodes high.
//
//   Optional feature macro: SEVEN_SEG_SCAN_DP_EN
//     defined   -> adds dp_in[N_DIGITS-1:0] and active-low dp output
//     undefined -> no decimal-point ports or logic
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      synchronous active-high reset
//   value      packed digit codes, value[4i+3:4i] = digit i (digit 0 rightmost)
//   load       capture value into the shadow register
//   digit_en   per-digit enable, 0 forces the digit blank
//   lz_blank   leading-zero suppression enable
//   nibble     code of the selected digit (decoder input)
//   anodes     active-low digit select, at most one bit low
//   digit_idx  index of the selected digit
//   dp_in/dp   (optional) per-digit decimal point in, active-low dp out
module seven_seg_scan_driver #(
   parameter int N_DIGITS    = 8,
   parameter int REFRESH_DIV = 100000,
   localparam int IDX_W      = $clog2(N_DIGITS),
   localparam int CNT_W      = $clog2(REFRESH_DIV)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*N_DIGITS-1:0]   value,
   input  logic                    load,
   input  logic [N_DIGITS-1:0]     digit_en,
   input  logic                    lz_blank,
`ifdef SEVEN_SEG_SCAN_DP_EN
   input  logic [N_DIGITS-1:0]     dp_in,
   output logic                    dp,
`endif
   output logic [3:0]              nibble,
   output logic [N_DIGITS-1:0]     anodes,
   output logic [IDX_W-1:0]        digit_idx
);

   logic [N_DIGITS-1:0][3:0] shadow_q, shadow_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [3:0]               nibble_q, nibble_d;
   logic [N_DIGITS-1:0]      anodes_q, anodes_d;
   logic [N_DIGITS-1:0]      blank;
   logic                     tick;
   logic                     upper_zero;
   logic                     sel_blank;
`ifdef SEVEN_SEG_SCAN_DP_EN
   logic                     dp_q, dp_d;
`endif

   always_comb begin
      shadow_d = load ? value : shadow_q;

      tick  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      idx_d = idx_q;
      if (tick)
         idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

      // Walk from the most significant digit down, tracking whether every
      // code at or above the current position is zero. Digit 0 is exempt so
      // a zero value still shows a single "0". Uses the pre-load shadow.
      upper_zero = 1'b1;
      blank      = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         upper_zero = upper_zero & (shadow_q[i] == 4'h0);
         blank[i]   = ~digit_en[i] | (lz_blank & (i != 0) & upper_zero);
      end

      // Outputs are registered from next_idx so anode and code switch together.
      sel_blank = blank[idx_d];
      nibble_d  = sel_blank ? 4'hF : shadow_q[idx_d];
      anodes_d  = '1;
      if (!sel_blank)
         anodes_d[idx_d] = 1'b0;
`ifdef SEVEN_SEG_SCAN_DP_EN
      dp_d = sel_blank | ~dp_in[idx_d];
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         nibble_q <= 4'hF;
         anodes_q <= '1;
`ifdef SEVEN_SEG_SCAN_DP_EN
         dp_q     <= 1'b1;
`endif
      end else begin
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         nibble_q <= nibble_d;
         anodes_q <= anodes_d;
`ifdef SEVEN_SEG_SCAN_DP_EN
         dp_q     <= dp_d;
`endif
      end
   end

   // idx_q is itself the registered next_idx, so it doubles as digit_idx.
   assign nibble    = nibble_q;
   assign anodes    = anodes_q;
   assign digit_idx = idx_q;
`ifdef SEVEN_SEG_SCAN_DP_EN
   assign dp        = dp_q;
`endif

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver (N_DIGITS=8, REFRESH_DIV=4).
// The reference model tracks only the number of scan edges since reset and
// the loaded value; the selected digit is derived arithmetically from that.
module tb_seven_seg_scan_driver;
   localparam int N  = 8;
   localparam int RD = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [4*N-1:0] value;
   logic           load;
   logic [N-1:0]   digit_en;
   logic           lz_blank;
   logic [3:0]     nibble;
   logic [N-1:0]   anodes;
   logic [2:0]     digit_idx;
`ifdef SEVEN_SEG_SCAN_DP_EN
   logic [N-1:0]   dp_in;
   logic           dp;
`endif

   seven_seg_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(RD)) dut (
      .clk(clk), .reset(reset), .value(value), .load(load),
      .digit_en(digit_en), .lz_blank(lz_blank),
`ifdef SEVEN_SEG_SCAN_DP_EN
      .dp_in(dp_in), .dp(dp),
`endif
      .nibble(nibble), .anodes(anodes), .digit_idx(digit_idx));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   nib;
      logic [N-1:0] an;
      logic [2:0]   idx;
      logic         dpo;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // reference model state
   int unsigned    p = 0;          // scan edges since reset
   logic [4*N-1:0] m_shadow = '0;

   function automatic exp_t predict();
      exp_t e;
      int   nx;
      bit   blk;
      e.nib = 4'hF; e.an = '1; e.idx = 3'd0; e.dpo = 1'b1;
      if (reset) return e;
      nx  = int'(((p + 1) / RD) % N);
      blk = !digit_en[nx] || (lz_blank && nx != 0 && (m_shadow >> (4 * nx)) == 0);
      e.idx = 3'(nx);
      if (!blk) begin
         e.nib = m_shadow[4*nx +: 4];
         e.an  = ~(8'(1) << nx);
`ifdef SEVEN_SEG_SCAN_DP_EN
         e.dpo = ~dp_in[nx];
`endif
      end
      return e;
   endfunction

   // one clock: predict from pre-edge state and inputs, push after the edge
   task automatic cycle();
      exp_t e;
      e = predict();
      @(posedge clk);
      sb.push_back(e);
      if (reset) begin
         p = 0; m_shadow = '0;
      end else begin
         if (load) m_shadow = value;
         p++;
      end
      #2;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   // monitor: every cycle presents an output, compare against the oldest prediction
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("nibble",    8'(nibble),    8'(e.nib));
         chk("anodes",    8'(anodes),    8'(e.an));
         chk("digit_idx", 8'(digit_idx), 8'(e.idx));
`ifdef SEVEN_SEG_SCAN_DP_EN
         chk("dp",        8'(dp),        8'(e.dpo));
`endif
      end
   end

   task automatic load_val(input logic [4*N-1:0] v);
      value = v; load = 1'b1; cycle(); load = 1'b0;
   endtask

   initial begin
      int wait_cnt;
      reset = 1'b1; value = '0; load = 1'b0; digit_en = '1; lz_blank = 1'b0;
`ifdef SEVEN_SEG_SCAN_DP_EN
      dp_in = 8'b0000_0100;
`endif
      #2;
      run(3);
      reset = 1'b0;
      run(8);

      // full sweep including wrap 7 -> 0
      load_val(32'h8765_4321);
      run(40);

      // leading-zero suppression, then an all-zero value
      lz_blank = 1'b1;
      load_val(32'h0000_0305);
      run(32);
      load_val(32'h0000_0000);
      run(32);
      lz_blank = 1'b0;

      // one disabled digit
      digit_en = 8'b1111_0111;
      load_val(32'h1111_1111);
      run(32);
      digit_en = '1;

      // codes 10..15 pass straight through
      load_val(32'hFEDC_BA98);
      run(32);

      // load on the tick edge: A shown for one cycle on the new digit, then B
      load_val(32'h1234_5678);
      while (((p + 1) % RD) != 0) cycle();
      load_val(32'h9ABC_DEF0);
      run(6);

      // reset in the middle of digit 5
      while (!((((p / RD) % N) == 5) && (p % RD) == 1)) cycle();
      reset = 1'b1; cycle(); reset = 1'b0;
      run(10);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset    = ($urandom_range(0, 299) == 0);
         load     = ($urandom_range(0, 9) == 0);
         value    = $urandom() >> (4 * $urandom_range(0, 7));
         digit_en = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : '1;
         lz_blank = 1'($urandom());
`ifdef SEVEN_SEG_SCAN_DP_EN
         dp_in    = 8'($urandom());
`endif
         cycle();
      end
      reset = 1'b0; load = 1'b0;

      wait_cnt = 0;
      while (sb.size() != 0 && wait_cnt < 5) begin
         @(posedge clk); wait_cnt++;
      end
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d predictions left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
